// File: rtl/prbs32_checker.sv
// rtl/prbs32_checker.sv - self-synchronising checker for lfsr32 word streams
// Seeds from the stream, flywheels its own expectation, counts word and bit errors.
module prbs32_checker #(
    parameter int CNT_W      = 32,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             DataValid,
    input  logic [31:0]      Data,
    input  logic             ClearCnt,
    output logic             Locked,
    output logic             ErrPulse,
    output logic [CNT_W-1:0] WordErrCount,
    output logic [CNT_W-1:0] BitErrCount,
    output logic [1:0]       State
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_LAST   = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] UNLOCK_LAST = BW'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q;
    logic [31:0]        exp_q;
    logic [GW-1:0]      good_q;
    logic [BW-1:0]      bad_q;
    logic               locked_q;
    logic               err_pulse_q;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

    logic [31:0]        seed_exp;
    logic [31:0]        flw_exp;
    logic [31:0]        diff;
    logic               mismatch;
    logic               count_err;
    logic [CNT_W+5:0]   bit_sum;

    // Thirty-two single-bit Fibonacci shifts of the lfsr32 register per word.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 32; i++) begin
            r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
        end
        return r;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    always_comb begin
        seed_exp   = lfsr_next(Data);
        flw_exp    = lfsr_next(exp_q);
        diff       = Data ^ exp_q;
        mismatch   = |diff;
        count_err  = DataValid && (state_q == LOCKED) && mismatch;
        bit_sum    = {6'd0, bit_cnt_q} + {{CNT_W{1'b0}}, popcount(diff)};
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        // A coincident clear wins, so the error of that cycle is never counted.
        if (ClearCnt) begin
            word_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (count_err) begin
            word_cnt_d = (&word_cnt_q) ? word_cnt_q : word_cnt_q + 1'b1;
            bit_cnt_d  = (|bit_sum[CNT_W+5:CNT_W]) ? {CNT_W{1'b1}} : bit_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state_q     <= SEED;
            exp_q       <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            word_cnt_q  <= '0;
            bit_cnt_q   <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            word_cnt_q  <= word_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            if (DataValid) begin
                case (state_q)
                    SEED: begin
                        if (Data != '0) begin
                            exp_q   <= seed_exp;
                            good_q  <= '0;
                            state_q <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (!mismatch) begin
                            exp_q  <= flw_exp;
                            good_q <= good_q + 1'b1;
                            if (good_q == LOCK_LAST) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                bad_q    <= '0;
                            end
                        end else begin
                            good_q <= '0;
                            if (Data != '0) begin
                                exp_q <= seed_exp;
                            end else begin
                                state_q <= SEED;
                            end
                        end
                    end
                    LOCKED: begin
                        exp_q <= flw_exp;
                        if (!mismatch) begin
                            bad_q <= '0;
                        end else begin
                            err_pulse_q <= 1'b1;
                            bad_q       <= bad_q + 1'b1;
                            if (bad_q == UNLOCK_LAST) begin
                                state_q  <= SEED;
                                locked_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= SEED;
                endcase
            end
        end
    end

    assign Locked       = locked_q;
    assign ErrPulse     = err_pulse_q;
    assign WordErrCount = word_cnt_q;
    assign BitErrCount  = bit_cnt_q;
    assign State        = state_q;

endmodule
